fmul_issue_ctrl: RTL

//  Upstream issue/collect controller for the 5-stage fmul pipeline. Accepts operand pairs over valid/ready,

---
 rtl/fmul_pkg.sv | 18 +
 rtl/op_skid_buf.sv | 50 +++++
 rtl/fmul_issue_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fmul_pkg.sv
// Shared constants and types for the fmul pipeline, its issue controller and benches.
package fmul_pkg;

  localparam int FMUL_LATENCY = 5;
  localparam int FP_W         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fmul_state_e;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/op_skid_buf.sv
// One-entry operand-pair buffer with valid/ready on both sides.
module op_skid_buf
  import fmul_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     s_valid_i,
  output logic     s_ready_o,
  input  op_pair_t s_data_i,
  output logic     m_valid_o,
  input  logic     m_ready_i,
  output op_pair_t m_data_o
);

  logic     full_q, full_d;
  op_pair_t data_q, data_d;

  assign s_ready_o = ~full_q;
  assign m_valid_o = full_q;
  assign m_data_o  = data_q;

  // Next-state: a push in the same cycle as a pop leaves the entry occupied.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (m_valid_o && m_ready_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
    if (s_valid_i && s_ready_o) begin
      full_d = 1'b1;
      data_d = s_data_i;
    end else begin
      data_d = data_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Issue/collect controller for the 5-stage fmul: holds operands stable for the
// whole multiply, captures the product and returns it over valid/ready.
module fmul_issue_ctrl
  import fmul_pkg::*;
#(
  parameter int LATENCY = FMUL_LATENCY,
  parameter int CNT_W   = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_a,
  input  logic [FP_W-1:0] in_b,
  output logic [FP_W-1:0] fm_a,
  output logic [FP_W-1:0] fm_b,
  input  logic [FP_W-1:0] fm_s,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_s,
  output logic            busy
);

  fmul_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0] fm_a_q, fm_a_d;
  logic [FP_W-1:0] fm_b_q, fm_b_d;
  logic [FP_W-1:0] out_s_q, out_s_d;
  logic            out_valid_q, out_valid_d;

  logic     skid_full_s;
  logic     skid_ready_s;
  logic     skid_push_s;
  logic     skid_pop_s;
  op_pair_t skid_data_s;
  op_pair_t in_pair_s;
  logic     in_xfer_s;
  logic     out_xfer_s;
  logic     load_s;
  logic     direct_s;

  assign in_ready   = skid_ready_s;
  assign in_xfer_s  = in_valid & skid_ready_s;
  assign out_xfer_s = out_valid_q & out_ready;
  assign in_pair_s  = '{a: in_a, b: in_b};

  // A load takes the buffered pair first; otherwise the incoming pair bypasses the buffer.
  assign direct_s    = load_s & ~skid_full_s;
  assign skid_pop_s  = load_s & skid_full_s;
  assign skid_push_s = in_valid & ~direct_s;

  op_skid_buf u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid_i (skid_push_s),
    .s_ready_o (skid_ready_s),
    .s_data_i  (in_pair_s),
    .m_valid_o (skid_full_s),
    .m_ready_i (skid_pop_s),
    .m_data_o  (skid_data_s)
  );

  // FSM next-state, latency counter, operand and result registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fm_a_d      = fm_a_q;
    fm_b_d      = fm_b_q;
    out_s_d     = out_s_q;
    out_valid_d = out_valid_q;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (skid_full_s || in_xfer_s) begin
          load_s  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // fmul re-samples the sign bits in its last stage, so nothing moves until capture.
        if (cnt_q == CNT_W'(LATENCY)) begin
          out_s_d     = fm_s;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_xfer_s) begin
          out_valid_d = 1'b0;
          if (skid_full_s || in_xfer_s) begin
            load_s  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
    if (load_s) begin
      fm_a_d = skid_full_s ? skid_data_s.a : in_a;
      fm_b_d = skid_full_s ? skid_data_s.b : in_b;
    end else begin
      fm_a_d = fm_a_q;
      fm_b_d = fm_b_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fm_a_q      <= '0;
      fm_b_q      <= '0;
      out_s_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fm_a_q      <= fm_a_d;
      fm_b_q      <= fm_b_d;
      out_s_q     <= out_s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fm_a      = fm_a_q;
  assign fm_b      = fm_b_q;
  assign out_s     = out_s_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE) | skid_full_s;

endmodule
